// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of IF/ID.
// Owns the PC and selects the next PC: sequential, D-stage branch/jump redirect, ERET,
// exception entry, or a redirect latched while the pipeline was stalled.
//
// Ports
//   clk, reset    clock and synchronous active-high reset
//   en            1 = F advances, 0 = stall (PC holds)
//   D_is_bj       D-stage instruction is a branch/jump (F holds its delay slot)
//   D_jump_take   D branch taken / jump (qualified by D_is_bj)
//   D_jump_tgt    redirect target from D
//   eret, epc     ERET in D and the CP0 EPC it returns to (no delay slot)
//   req           CP0 exception/interrupt request, overrides everything including stall
//   i_inst_rdata  instruction memory read data (combinational)
//   i_inst_addr   instruction memory address (= F_pc)
//   F_pc, F_instr, F_exc_code, F_b_judge   fetch results handed to IF/ID
//   fetch_cnt     number of instructions handed to IF/ID
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE   = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        D_is_bj,
  input  logic        D_jump_take,
  input  logic [31:0] D_jump_tgt,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        req,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic [4:0]  F_exc_code,
  output logic        F_b_judge,
  output logic [31:0] fetch_cnt
);

  // Window end computed in 33 bits so a window touching 2^32 cannot wrap.
  localparam logic [32:0] ImEnd    = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
  localparam logic [4:0]  ExcAdEL  = 5'd4;

  typedef enum logic [0:0] {StRun, StPend} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic redirect;
  logic addr_err;

  assign redirect = (D_is_bj & D_jump_take) | eret;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      pc_q        <= PC_RESET;
      pend_tgt_q  <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Next-PC selection and PEND bookkeeping.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_tgt_d  = pend_tgt_q;
    fetch_cnt_d = fetch_cnt_q;

    if (en && !req) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end

    if (req) begin
      // Exception entry wins even over a stall; any latched redirect is dropped.
      pc_d       = EXC_ENTRY;
      state_d    = StRun;
      pend_tgt_d = '0;
    end else if (!en) begin
      // Only the first redirect seen during a stall is kept.
      if (state_q == StRun && redirect) begin
        state_d    = StPend;
        pend_tgt_d = eret ? epc : D_jump_tgt;
      end
    end else if (state_q == StPend) begin
      pc_d    = pend_tgt_q;
      state_d = StRun;
    end else if (eret) begin
      pc_d = epc;
    end else if (D_is_bj && D_jump_take) begin
      pc_d = D_jump_tgt;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Fetch outputs.
  always_comb begin
    addr_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= ImEnd);

    i_inst_addr = pc_q;
    F_pc        = pc_q;
    F_exc_code  = addr_err ? ExcAdEL : 5'd0;
    // The instruction after ERET is not executed; in PEND it has already been squashed.
    F_instr     = (addr_err || (eret && state_q == StRun)) ? 32'd0 : i_inst_rdata;
    // In PEND the delay slot was already consumed before the stall.
    F_b_judge   = D_is_bj && !eret && (state_q == StRun);
    fetch_cnt   = fetch_cnt_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, en, D_is_bj, D_jump_take, eret, req;
  logic [31:0] D_jump_tgt, epc, i_inst_rdata;
  logic [31:0] i_inst_addr, F_pc, F_instr, fetch_cnt;
  logic [4:0]  F_exc_code;
  logic        F_b_judge;

  int checks = 0;
  int errors = 0;

  // Reference model state: PC, count, and a queue holding at most one latched redirect.
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  logic [31:0] m_pend[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .D_is_bj      (D_is_bj),
    .D_jump_take  (D_jump_take),
    .D_jump_tgt   (D_jump_tgt),
    .eret         (eret),
    .epc          (epc),
    .req          (req),
    .i_inst_rdata (i_inst_rdata),
    .i_inst_addr  (i_inst_addr),
    .F_pc         (F_pc),
    .F_instr      (F_instr),
    .F_exc_code   (F_exc_code),
    .F_b_judge    (F_b_judge),
    .fetch_cnt    (fetch_cnt)
  );

  function automatic logic [4:0] exp_exc();
    if ((m_pc % 4) != 0 || m_pc < 32'h3000 || m_pc >= 32'h7000) return 5'd4;
    return 5'd0;
  endfunction

  function automatic logic [31:0] exp_instr();
    if (exp_exc() != 0) return 32'd0;
    if (eret && m_pend.size() == 0) return 32'd0;
    return i_inst_rdata;
  endfunction

  function automatic logic exp_bj();
    return D_is_bj && !eret && m_pend.size() == 0;
  endfunction

  // Advance the model with the inputs present at this edge, then the clock.
  task automatic tick();
    if (reset) begin
      m_pc = 32'h3000;
      m_cnt = 0;
      m_pend.delete();
    end else begin
      if (en && !req) m_cnt = m_cnt + 1;
      if (req) begin
        m_pc = 32'h4180;
        m_pend.delete();
      end else if (!en) begin
        if (m_pend.size() == 0 && ((D_is_bj && D_jump_take) || eret))
          m_pend.push_back(eret ? epc : D_jump_tgt);
      end else if (m_pend.size() != 0) begin
        m_pc = m_pend.pop_front();
      end else if (eret) begin
        m_pc = epc;
      end else if (D_is_bj && D_jump_take) begin
        m_pc = D_jump_tgt;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; en = 1; D_is_bj = 0; D_jump_take = 0; D_jump_tgt = 0;
    eret = 0; epc = 0; req = 0; i_inst_rdata = $urandom;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
    checks++;
    if (F_pc !== 32'h3000) begin
      errors++; $display("FAIL reset_pc got=%h exp=%h", F_pc, 32'h3000);
    end
    checks++;
    if (i_inst_addr !== 32'h3000) begin
      errors++; $display("FAIL reset_addr got=%h exp=%h", i_inst_addr, 32'h3000);
    end
    checks++;
    if (fetch_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt);
    end
    checks++;
    if (F_exc_code !== 5'd0) begin
      errors++; $display("FAIL reset_exc got=%0d exp=0", F_exc_code);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      i_inst_rdata = $urandom;
      #1;
      checks++;
      if (F_pc !== exp_pc) begin
        errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, F_pc, exp_pc);
      end
      checks++;
      if (F_instr !== i_inst_rdata) begin
        errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, F_instr, i_inst_rdata);
      end
      tick();
      exp_pc = exp_pc + 4;
    end
    checks++;
    if (fetch_cnt !== 32'd4) begin
      errors++; $display("FAIL seq_cnt got=%0d exp=4", fetch_cnt);
    end
  endtask

  task automatic test_branch();
    D_is_bj = 1; D_jump_take = 1; D_jump_tgt = 32'h3100;
    #1;
    checks++;
    if (F_b_judge !== 1'b1) begin
      errors++; $display("FAIL br_bjudge got=%b exp=1", F_b_judge);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (F_pc !== 32'h3100) begin
      errors++; $display("FAIL br_pc got=%h exp=%h", F_pc, 32'h3100);
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] held;
    held = F_pc;
    en = 0; D_is_bj = 1; D_jump_take = 1; D_jump_tgt = 32'h3200;
    tick();
    D_jump_tgt = 32'h3300;  // must be ignored: first latched target wins
    #1;
    checks++;
    if (F_b_judge !== 1'b0) begin
      errors++; $display("FAIL pend_bjudge got=%b exp=0", F_b_judge);
    end
    tick();
    tick();
    checks++;
    if (F_pc !== held) begin
      errors++; $display("FAIL pend_hold got=%h exp=%h", F_pc, held);
    end
    idle_inputs();
    tick();
    checks++;
    if (F_pc !== 32'h3200) begin
      errors++; $display("FAIL pend_release got=%h exp=%h", F_pc, 32'h3200);
    end
  endtask

  task automatic test_eret();
    eret = 1; epc = 32'h3040; D_is_bj = 1; i_inst_rdata = 32'hdead_beef;
    #1;
    checks++;
    if (F_instr !== 32'd0) begin
      errors++; $display("FAIL eret_instr got=%h exp=0", F_instr);
    end
    checks++;
    if (F_b_judge !== 1'b0) begin
      errors++; $display("FAIL eret_bjudge got=%b exp=0", F_b_judge);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (F_pc !== 32'h3040) begin
      errors++; $display("FAIL eret_pc got=%h exp=%h", F_pc, 32'h3040);
    end
  endtask

  task automatic test_req();
    en = 0; D_is_bj = 1; D_jump_take = 1; D_jump_tgt = 32'h3500;
    tick();
    req = 1; D_is_bj = 0; D_jump_take = 0;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (F_pc !== 32'h4180) begin
      errors++; $display("FAIL req_pc got=%h exp=%h", F_pc, 32'h4180);
    end
    D_is_bj = 1; D_jump_take = 1; D_jump_tgt = 32'h2ffc;
    #1;
    checks++;
    if (F_b_judge !== 1'b1) begin
      errors++; $display("FAIL req_run got=%b exp=1", F_b_judge);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (F_pc !== 32'h2ffc || F_exc_code !== 5'd4 || F_instr !== 32'd0) begin
      errors++;
      $display("FAIL req_low_exc pc=%h exc=%0d instr=%h exp pc=2ffc exc=4 instr=0",
               F_pc, F_exc_code, F_instr);
    end
  endtask

  task automatic test_exc();
    logic [31:0] tgts[3];
    logic [4:0]  codes[3];
    tgts = '{32'h3002, 32'h7000, 32'h6ffc};
    codes = '{5'd4, 5'd4, 5'd0};
    for (int i = 0; i < 3; i++) begin
      D_is_bj = 1; D_jump_take = 1; D_jump_tgt = tgts[i];
      tick();
      idle_inputs();
      #1;
      checks++;
      if (F_pc !== tgts[i] || F_exc_code !== codes[i]) begin
        errors++;
        $display("FAIL exc[%0d] pc=%h exc=%0d exp pc=%h exc=%0d",
                 i, F_pc, F_exc_code, tgts[i], codes[i]);
      end
    end
  endtask

  task automatic test_reset_pend();
    en = 0; eret = 1; epc = 32'h3600;
    tick();
    reset = 1; eret = 0;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (F_pc !== 32'h3000 || fetch_cnt !== 32'd0) begin
      errors++; $display("FAIL rstpend pc=%h cnt=%0d exp pc=3000 cnt=0", F_pc, fetch_cnt);
    end
    tick();
    checks++;
    if (F_pc !== 32'h3004) begin
      errors++; $display("FAIL rstpend_run got=%h exp=%h", F_pc, 32'h3004);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool[6];
    pool = '{32'h3000, 32'h3ffc, 32'h6ffc, 32'h3102, 32'h2ff0, 32'h7004};
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(99) < 2);
      en          = ($urandom_range(99) < 70);
      req         = ($urandom_range(99) < 5);
      D_is_bj     = ($urandom_range(99) < 30);
      D_jump_take = $urandom_range(1);
      eret        = ($urandom_range(99) < 8);
      D_jump_tgt  = pool[$urandom_range(5)];
      epc         = pool[$urandom_range(5)];
      i_inst_rdata = $urandom;
      #1;
      checks++;
      if (F_pc !== m_pc || i_inst_addr !== m_pc) begin
        errors++; $display("FAIL rnd_pc[%0d] got=%h/%h exp=%h", i, F_pc, i_inst_addr, m_pc);
      end
      checks++;
      if (F_instr !== exp_instr() || F_exc_code !== exp_exc()) begin
        errors++;
        $display("FAIL rnd_out[%0d] instr=%h exc=%0d exp instr=%h exc=%0d",
                 i, F_instr, F_exc_code, exp_instr(), exp_exc());
      end
      checks++;
      if (F_b_judge !== exp_bj()) begin
        errors++; $display("FAIL rnd_bjudge[%0d] got=%b exp=%b", i, F_b_judge, exp_bj());
      end
      checks++;
      if (fetch_cnt !== m_cnt) begin
        errors++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, fetch_cnt, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_redirect();
    test_eret();
    test_req();
    test_exc();
    test_reset_pend();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
